// File: rtl/bike_pkg.sv
// -----------------------------------------------------------------------------
// bike_pkg
//  Shared definitions for the bike orientation front end: the 2-bit direction
//  code, its named values, the reversal helper and the player count.
//  Encoding: UP=0, RIGHT=1, DOWN=2, LEFT=3. Flipping bit 1 gives the opposite
//  direction, so a reversal is a single XOR.
// -----------------------------------------------------------------------------
package bike_pkg;

   typedef logic [1:0] orient_t;

   localparam orient_t ORIENT_UP    = 2'd0;
   localparam orient_t ORIENT_RIGHT = 2'd1;
   localparam orient_t ORIENT_DOWN  = 2'd2;
   localparam orient_t ORIENT_LEFT  = 2'd3;

   localparam int NUM_PLAYERS = 4;

   function automatic orient_t reverse_of(input orient_t o);
      return o ^ 2'b10;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//  One raw push button -> 2-flop synchroniser -> level debouncer.
//  The accepted level only changes after the synchronised input has disagreed
//  with it for DEBOUNCE_CYCLES consecutive cycles; any agreement in between
//  clears the count, so bounces never get through. Press-to-event latency is
//  2 + DEBOUNCE_CYCLES cycles.
// Ports
//  clock  in   system clock
//  reset  in   asynchronous active-low reset
//  raw    in   asynchronous button, active-high
//  level  out  debounced (accepted) level
//  press  out  one-cycle pulse on a 0->1 change of the accepted level
// -----------------------------------------------------------------------------
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            // Disagreement has lasted long enough: accept the new level.
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/bike_orient_ctrl.sv
// -----------------------------------------------------------------------------
// bike_orient_ctrl
//  Player input front end for the four light-cycles. Debounces 16 direction
//  buttons, filters out reversals and no-op turns, holds one pending turn per
//  player and commits all players together on move_tick.
// Ports
//  clock                in   system clock
//  reset                in   asynchronous active-low reset
//  masterSwitch         in   1 = running, 0 = halted (orientations held at INIT)
//  move_tick            in   one-cycle commit pulse per game step
//  btn[15:0]            in   raw buttons; player p uses btn[4p+3:4p] = {LEFT,DOWN,RIGHT,UP}
//  bike*Orient_IN[31:0] out  committed orientation per player, {30'b0, code}
//  turn_pending[3:0]    out  bit p = player p holds an uncommitted legal turn
// -----------------------------------------------------------------------------
module bike_orient_ctrl
   import bike_pkg::*;
#(
   parameter int      DEBOUNCE_CYCLES = 250000,
   parameter int      CNT_W           = 18,
   parameter orient_t INIT_P1         = ORIENT_RIGHT,
   parameter orient_t INIT_P2         = ORIENT_LEFT,
   parameter orient_t INIT_P3         = ORIENT_DOWN,
   parameter orient_t INIT_P4         = ORIENT_UP
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        masterSwitch,
   input  logic        move_tick,
   input  logic [15:0] btn,
   output logic [31:0] bikeoneOrient_IN,
   output logic [31:0] biketwoOrient_IN,
   output logic [31:0] bikethreeOrient_IN,
   output logic [31:0] bikefourOrient_IN,
   output logic [3:0]  turn_pending
);

   localparam logic [7:0] INIT_VEC = {INIT_P4, INIT_P3, INIT_P2, INIT_P1};

   logic [15:0] press_vec;
   logic [15:0] unused_level_vec;
   orient_t     committed_all [NUM_PLAYERS];

   for (genvar b = 0; b < 16; b++) begin : btn_g
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clock (clock),
         .reset (reset),
         .raw   (btn[b]),
         .level (unused_level_vec[b]),
         .press (press_vec[b])
      );
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : player_g
      localparam orient_t INIT_O = INIT_VEC[2*p +: 2];

      // Button bit index within the player's nibble equals the direction code.
      logic [3:0] ev;
      logic [3:0] legal;
      logic       take;
      orient_t    cand;
      orient_t    committed_q, committed_d;
      orient_t    pending_q,   pending_d;
      logic       tp_q,        tp_d;

      assign ev = press_vec[4*p +: 4];

      always_comb begin
         // Legality is judged against the committed heading, never the pending
         // one, so a chain of turns inside one tick cannot build a reversal.
         legal = '0;
         for (int d = 0; d < 4; d++) begin
            legal[d] = ev[d]
                       && (orient_t'(d) != committed_q)
                       && (orient_t'(d) != reverse_of(committed_q));
         end
         // Lowest code wins among legal candidates: UP > RIGHT > DOWN > LEFT.
         take = 1'b0;
         cand = ORIENT_UP;
         for (int d = 3; d >= 0; d--) begin
            if (legal[d]) begin
               take = 1'b1;
               cand = orient_t'(d);
            end
         end

         committed_d = committed_q;
         pending_d   = pending_q;
         tp_d        = tp_q;
         if (!masterSwitch) begin
            committed_d = INIT_O;
            pending_d   = INIT_O;
            tp_d        = 1'b0;
         end else if (move_tick) begin
            // A press landing on the tick is dropped on purpose.
            committed_d = pending_q;
            tp_d        = 1'b0;
         end else if (take) begin
            pending_d = cand;
            tp_d      = 1'b1;
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            committed_q <= INIT_O;
            pending_q   <= INIT_O;
            tp_q        <= 1'b0;
         end else begin
            committed_q <= committed_d;
            pending_q   <= pending_d;
            tp_q        <= tp_d;
         end
      end

      assign committed_all[p] = committed_q;
      assign turn_pending[p]  = tp_q;
   end

   assign bikeoneOrient_IN   = {30'b0, committed_all[0]};
   assign biketwoOrient_IN   = {30'b0, committed_all[1]};
   assign bikethreeOrient_IN = {30'b0, committed_all[2]};
   assign bikefourOrient_IN  = {30'b0, committed_all[3]};

endmodule
